// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream bundle driven by fifo_stream_reader.
// Ports: m_valid/m_data from master, m_ready from slave.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a sync FIFO (1-cycle read latency) into a 2-entry skid buffer
// and streams words in order on a valid/ready master interface.
// Ports: clk, rst (sync, active-high), fifo_empty/fifo_rd_en/
// fifo_rd_data (FIFO read port), flush, rd_count, busy, m (stream).
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy,
  fifo_stream_reader_if.master  m
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] spare_q;
  logic                  inflight;
  logic                  pop;
  logic [1:0]            occ;
  logic [2:0]            need;
  logic                  load_out;
  logic                  load_spare;
  logic                  shift;

  assign occ       = state;
  assign pop       = m.m_valid && m.m_ready;
  assign m.m_valid = (state != S_EMPTY);
  assign m.m_data  = out_q;
  assign busy      = (state != S_EMPTY) || inflight;

  // Slots committed after this edge; keep it below 2 so an
  // arriving word always has a place to land.
  assign need = {1'b0, occ}
              + {2'b00, inflight}
              - {2'b00, pop};

  assign fifo_rd_en = !rst && !flush && !fifo_empty
                    && (need < 3'd2);

  always_comb begin
    state_n    = state;
    load_out   = 1'b0;
    load_spare = 1'b0;
    shift      = 1'b0;
    if (flush) begin
      // In-flight data is dropped: no capture this edge.
      state_n = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (inflight) begin
            load_out = 1'b1;
            state_n  = S_ONE;
          end
        end
        S_ONE: begin
          unique case (1'b1)
            inflight && pop: begin
              load_out = 1'b1;
            end
            !inflight && pop: begin
              state_n = S_EMPTY;
            end
            inflight && !pop: begin
              load_spare = 1'b1;
              state_n    = S_TWO;
            end
            default: begin
              state_n = S_ONE;
            end
          endcase
        end
        S_TWO: begin
          if (pop) begin
            shift = 1'b1;
            if (inflight) begin
              load_spare = 1'b1;
            end else begin
              state_n = S_ONE;
            end
          end
        end
        default: begin
          state_n = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_EMPTY;
      inflight <= 1'b0;
      out_q    <= '0;
      spare_q  <= '0;
      rd_count <= '0;
    end else begin
      state    <= state_n;
      inflight <= fifo_rd_en;
      if (load_out) begin
        out_q <= fifo_rd_data;
      end else if (shift) begin
        out_q <= spare_q;
      end
      if (load_spare) begin
        spare_q <= fifo_rd_data;
      end
      if (pop) begin
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized bench for fifo_stream_reader with a
// behavioural 1-cycle-latency FIFO and an in-order scoreboard.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data = 8'h00;
  logic [3:0] rd_count;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [7:0] exp_q[$];

  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) s_if ();

  fifo_stream_reader #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .flush       (flush),
    .rd_count    (rd_count),
    .busy        (busy),
    .m           (s_if)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
    end
  end

  typedef struct {
    int         npush;
    logic [7:0] base;
    logic       rdy;
    logic       en;
    logic       vld;
    logic [7:0] dat;
    logic       bsy;
    int         cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + 8'(i);
      wr_ptr      = wr_ptr + 8'd1;
      exp_q.push_back(base + 8'(i));
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later.
  task automatic step(input int n, input logic [7:0] base,
                      input logic rdy, input logic fl);
    logic [7:0] e;
    @(negedge clk);
    push(n, base);
    s_if.m_ready = rdy;
    flush        = fl;
    #1;
    chk("rd_en_while_empty",
        32'(fifo_rd_en && fifo_empty), 0);
    if (s_if.m_valid && s_if.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got %0h want none",
                 s_if.m_data);
      end else begin
        e = exp_q.pop_front();
        chk("stream_data", 32'(s_if.m_data), 32'(e));
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step(0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    step(0, 8'h00, 1'b1, 1'b0);
    chk("drain_valid", 32'(s_if.m_valid), 0);
    chk("drain_busy", 32'(busy), 0);
  endtask

  initial begin
    int first;
    int last;
    int nv;
    int pushed;
    int np;
    int n;

    s_if.m_ready = 1'b0;

    tbl[0]  = '{1, 8'hA5, 1, 1, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 8'h00, 1, 0, 0, 8'h00, 1, 0};
    tbl[2]  = '{0, 8'h00, 1, 0, 1, 8'hA5, 1, 0};
    tbl[3]  = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 1};
    tbl[4]  = '{6, 8'h10, 0, 1, 0, 8'h00, 0, 1};
    tbl[5]  = '{0, 8'h00, 0, 1, 0, 8'h00, 1, 1};
    tbl[6]  = '{0, 8'h00, 0, 0, 1, 8'h10, 1, 1};
    tbl[7]  = '{0, 8'h00, 0, 0, 1, 8'h10, 1, 1};
    tbl[8]  = '{0, 8'h00, 0, 0, 1, 8'h10, 1, 1};
    tbl[9]  = '{0, 8'h00, 0, 0, 1, 8'h10, 1, 1};
    tbl[10] = '{0, 8'h00, 1, 1, 1, 8'h10, 1, 1};
    tbl[11] = '{0, 8'h00, 1, 1, 1, 8'h11, 1, 2};
    tbl[12] = '{0, 8'h00, 1, 1, 1, 8'h12, 1, 3};
    tbl[13] = '{0, 8'h00, 1, 1, 1, 8'h13, 1, 4};
    tbl[14] = '{0, 8'h00, 1, 0, 1, 8'h14, 1, 5};
    tbl[15] = '{0, 8'h00, 1, 0, 1, 8'h15, 1, 6};
    tbl[16] = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 7};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(s_if.m_valid), 0);
    chk("rst_data", 32'(s_if.m_data), 0);
    chk("rst_count", 32'(rd_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    rst = 1'b0;

    // Single word, then 6-cycle backpressure.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].npush, tbl[i].base, tbl[i].rdy, 1'b0);
      chk($sformatf("vec%0d_rd_en", i),
          32'(fifo_rd_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d_valid", i),
          32'(s_if.m_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d_data", i),
            32'(s_if.m_data), 32'(tbl[i].dat));
      end
      chk($sformatf("vec%0d_busy", i),
          32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d_count", i),
          32'(rd_count), 32'(tbl[i].cnt));
    end
    exp_cnt = 7;

    // Streaming 0x01..0x08 at full rate.
    first = -1;
    last  = -1;
    nv    = 0;
    for (int i = 0; i < 12; i++) begin
      step((i == 0) ? 8 : 0, 8'h01, 1'b1, 1'b0);
      if (s_if.m_valid) begin
        if (first < 0) first = i;
        last = i;
        nv++;
      end
    end
    exp_cnt += 8;
    chk("stream_first", first, 2);
    chk("stream_last", last, 9);
    chk("stream_nvalid", nv, 8);
    chk("stream_left", exp_q.size(), 0);
    chk("stream_count", 32'(rd_count), 32'(exp_cnt[3:0]));

    // Flush with one word buffered and one in flight.
    step(8, 8'h20, 1'b0, 1'b0);
    step(0, 8'h00, 1'b0, 1'b0);
    chk("pre_flush_rd_en", 32'(fifo_rd_en), 1);
    step(0, 8'h00, 1'b0, 1'b1);
    chk("flush_rd_en", 32'(fifo_rd_en), 0);
    chk("flush_valid_in", 32'(s_if.m_valid), 1);
    chk("flush_data_in", 32'(s_if.m_data), 32'h20);
    chk("flush_busy_in", 32'(busy), 1);
    step(0, 8'h00, 1'b1, 1'b0);
    chk("flush_valid_out", 32'(s_if.m_valid), 0);
    chk("flush_busy_out", 32'(busy), 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    drain();
    exp_cnt += 6;
    chk("flush_count", 32'(rd_count), 32'(exp_cnt[3:0]));

    // Random ready and random FIFO fill.
    pushed = 0;
    n      = 0;
    while ((pushed < 64 || exp_q.size() != 0) && n < 3000) begin
      np = (pushed < 64 && $urandom_range(0, 1) == 1) ? 1 : 0;
      step(np, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      pushed += np;
      n++;
    end
    chk("rand_pushed", pushed, 64);
    drain();
    exp_cnt += 64;
    chk("rand_count", 32'(rd_count), 32'(exp_cnt[3:0]));

    // Wrap at 17 words, then reset with occ=2.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(17, 8'h40, 1'b1, 1'b0);
    drain();
    chk("wrap_count", 32'(rd_count), 1);
    step(2, 8'h60, 1'b0, 1'b0);
    step(0, 8'h00, 1'b0, 1'b0);
    step(0, 8'h00, 1'b0, 1'b0);
    step(0, 8'h00, 1'b0, 1'b0);
    chk("full_valid", 32'(s_if.m_valid), 1);
    chk("full_data", 32'(s_if.m_data), 32'h60);
    chk("full_rd_en", 32'(fifo_rd_en), 0);
    @(negedge clk);
    push(1, 8'h70);
    s_if.m_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_hold_rd_en", 32'(fifo_rd_en), 0);
    @(negedge clk);
    #1;
    chk("rst2_valid", 32'(s_if.m_valid), 0);
    chk("rst2_data", 32'(s_if.m_data), 0);
    chk("rst2_count", 32'(rd_count), 0);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_rd_en", 32'(fifo_rd_en), 0);
    rst = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    drain();
    chk("post_rst_count", 32'(rd_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
